// File: rtl/rvga_lsu.sv
`default_nettype none
// ============================================================================
// rvga_lsu : word load/store unit to a line-wide memory port, with optional
//            splitting of accesses that straddle a line boundary.
// Revision : 1.0
// ============================================================================
module rvga_lsu #(
    parameter int unsigned LINE_WIDTH    = 128,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter bit          MISALIGNED_EN = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_v_i,
    output logic                    req_ready_o,
    input  logic                    req_store_i,
    input  logic [2:0]              req_op_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [31:0]             req_data_i,
    output logic                    mem_v_o,
    input  logic                    mem_ready_i,
    output logic                    mem_w_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [LINE_WIDTH-1:0]   mem_data_o,
    output logic [LINE_WIDTH/8-1:0] mem_mask_o,
    input  logic                    mem_v_i,
    input  logic [LINE_WIDTH-1:0]   mem_data_i,
    output logic                    resp_v_o,
    output logic [31:0]             resp_data_o,
    output logic                    resp_err_o
);
    localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
    localparam int unsigned OFF_W      = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ0 = 3'd1,
        S_RSP0 = 3'd2,
        S_REQ1 = 3'd3,
        S_RSP1 = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t r_state, w_state_nxt;

    logic                  r_store;
    logic [2:0]            r_op;
    logic [OFF_W-1:0]      r_off;
    logic [ADDR_WIDTH-1:0] r_line;
    logic                  r_split;
    logic [2:0]            r_cnt0;
    logic [31:0]           r_data;
    logic [3:0]            r_mask4;
    logic [31:0]           r_buf;

    logic [2:0]       w_size;
    logic [3:0]       w_mask4;
    logic [31:0]      w_sdata;
    logic             w_illegal, w_misal, w_err, w_split;
    logic [OFF_W:0]   w_end;
    logic [OFF_W:0]   w_rem;
    logic [2:0]       w_cnt0;
    logic             w_accept;

    // Request decode, evaluated on the raw request so it can be captured in one edge
    always_comb begin
        case (req_op_i[1:0])
            2'd0:    begin w_size = 3'd1; w_mask4 = 4'b0001; w_sdata = {24'd0, req_data_i[7:0]};  end
            2'd1:    begin w_size = 3'd2; w_mask4 = 4'b0011; w_sdata = {16'd0, req_data_i[15:0]}; end
            default: begin w_size = 3'd4; w_mask4 = 4'b1111; w_sdata = req_data_i;                end
        endcase
        w_illegal = req_store_i ? (req_op_i > 3'd2)
                                : ((req_op_i == 3'd3) || (req_op_i[2:1] == 2'b11));
        w_misal   = ((w_size == 3'd2) && req_addr_i[0]) ||
                    ((w_size == 3'd4) && (req_addr_i[1:0] != 2'b00));
        w_err     = w_illegal || (!MISALIGNED_EN && w_misal);
        w_end     = {1'b0, req_addr_i[OFF_W-1:0]} + (OFF_W+1)'(w_size);
        w_split   = (w_end > (OFF_W+1)'(LINE_BYTES));
        w_rem     = (OFF_W+1)'(LINE_BYTES) - {1'b0, req_addr_i[OFF_W-1:0]};
        w_cnt0    = w_split ? w_rem[2:0] : w_size;
    end

    assign w_accept = (r_state == S_IDLE) && req_v_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (req_v_i)     w_state_nxt = w_err ? S_ERR : S_REQ0;
            S_REQ0: if (mem_ready_i) w_state_nxt = S_RSP0;
            S_RSP0: if (mem_v_i)     w_state_nxt = r_split ? S_REQ1 : S_DONE;
            S_REQ1: if (mem_ready_i) w_state_nxt = S_RSP1;
            S_RSP1: if (mem_v_i)     w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            S_ERR:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    logic [LINE_WIDTH-1:0] w_rd_shift;
    assign w_rd_shift = mem_data_i >> {r_off, 3'b000};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_store <= 1'b0;
            r_op    <= 3'd0;
            r_off   <= '0;
            r_line  <= '0;
            r_split <= 1'b0;
            r_cnt0  <= 3'd0;
            r_data  <= 32'd0;
            r_mask4 <= 4'd0;
            r_buf   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_store <= req_store_i;
                r_op    <= req_op_i;
                r_off   <= req_addr_i[OFF_W-1:0];
                r_line  <= {req_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                r_split <= w_split;
                r_cnt0  <= w_cnt0;
                r_data  <= w_sdata;
                r_mask4 <= w_mask4;
                r_buf   <= 32'd0;
            end
            // Beat 0 bytes land at buffer byte 0; beat 1 continues after them
            if ((r_state == S_RSP0) && mem_v_i)
                r_buf <= w_rd_shift[31:0];
            if ((r_state == S_RSP1) && mem_v_i)
                r_buf <= r_buf | (mem_data_i[31:0] << {r_cnt0, 3'b000});
        end
    end

    // Lanes beyond the end of the line spill into the upper word: that is beat 1
    logic [LINE_WIDTH+31:0] w_wide_data;
    logic [LINE_BYTES+3:0]  w_wide_mask;
    logic                   w_beat1;
    assign w_wide_data = {{LINE_WIDTH{1'b0}}, r_data} << {r_off, 3'b000};
    assign w_wide_mask = {{LINE_BYTES{1'b0}}, r_mask4} << r_off;
    assign w_beat1     = (r_state == S_REQ1);

    always_comb begin
        mem_v_o    = (r_state == S_REQ0) || (r_state == S_REQ1);
        mem_w_o    = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_mask_o = '0;
        if (mem_v_o) begin
            mem_w_o    = r_store;
            mem_addr_o = w_beat1 ? (r_line + ADDR_WIDTH'(LINE_BYTES)) : r_line;
            if (r_store) begin
                mem_data_o = w_beat1 ? LINE_WIDTH'(w_wide_data[LINE_WIDTH+31:LINE_WIDTH])
                                     : w_wide_data[LINE_WIDTH-1:0];
                mem_mask_o = w_beat1 ? LINE_BYTES'(w_wide_mask[LINE_BYTES+3:LINE_BYTES])
                                     : w_wide_mask[LINE_BYTES-1:0];
            end
        end
    end

    always_comb begin
        req_ready_o = (r_state == S_IDLE);
        resp_v_o    = (r_state == S_DONE) || (r_state == S_ERR);
        resp_err_o  = (r_state == S_ERR);
        resp_data_o = 32'd0;
        if ((r_state == S_DONE) && !r_store) begin
            case (r_op)
                3'd0:    resp_data_o = {{24{r_buf[7]}}, r_buf[7:0]};
                3'd1:    resp_data_o = {{16{r_buf[15]}}, r_buf[15:0]};
                3'd4:    resp_data_o = {24'd0, r_buf[7:0]};
                3'd5:    resp_data_o = {16'd0, r_buf[15:0]};
                default: resp_data_o = r_buf;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/rvga_lsu.md
Name: rvga_lsu

Overview:
- Parametrised load/store unit for the rvga RV32I core. Sits between execute and the line-wide data memory port.
- Takes one word-level load or store per request. The funct3 field uses the core's load-op and store-op encodings.
- Converts each request into one or two line-granular memory transactions with byte masks. Returns the aligned, sign- or zero-extended load result.
- Generalises the fixed 128-bit line to LINE_WIDTH. Adds hardware splitting of misaligned accesses that cross a line boundary.

Parameters:
- LINE_WIDTH, 128: memory line width in bits. Power of 2, ≥ 32. LINE_BYTES = LINE_WIDTH/8.
- ADDR_WIDTH, 32: byte address width.
- MISALIGNED_EN, 1: 1 = misaligned accesses are handled and split when needed; 0 = misaligned accesses return an error.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- req_v_i  in  1  request valid
- req_ready_o  out  1  unit can accept a request
- req_store_i  in  1  1 = store, 0 = load
- req_op_i  in  3  funct3 (load-op for loads, store-op for stores)
- req_addr_i  in  ADDR_WIDTH  byte address
- req_data_i  in  32  store data
- mem_v_o  out  1  memory request valid
- mem_ready_i  in  1  memory accepts the request
- mem_w_o  out  1  1 = write
- mem_addr_o  out  ADDR_WIDTH  line-aligned address (low log2(LINE_BYTES) bits = 0)
- mem_data_o  out  LINE_WIDTH  write data, placed in byte lanes
- mem_mask_o  out  LINE_BYTES  byte write enables (all zero on reads)
- mem_v_i  in  1  memory response valid (read data or write ack)
- mem_data_i  in  LINE_WIDTH  read line
- resp_v_o  out  1  one-cycle response pulse
- resp_data_o  out  32  load result (0 for stores)
- resp_err_o  out  1  misaligned (when MISALIGNED_EN=0) or illegal funct3

Behaviour:
- Reset state: IDLE. req_ready_o=1. mem_v_o, resp_v_o, resp_err_o = 0. Every data, address and mask output = 0.
- Lane mapping is little-endian: line byte i occupies bits [8i+7:8i]. Access size is 1, 2 or 4 bytes (lb/lbu/sb = 1, lh/lhu/sh = 2, lw/sw = 4).
- Request acceptance: a request is accepted when req_v_i && req_ready_o. req_ready_o=1 only in IDLE. All request fields are captured on the accepting edge.
- Legality check at acceptance:
  - Illegal funct3: loads 3, 6, 7; stores ≥ 3.
  - Misaligned with MISALIGNED_EN=0: addr not a multiple of size.
  - Either case: go to ERR. resp_v_o=1 and resp_err_o=1 in the next cycle. No memory traffic. Return to IDLE.
- Split condition: off = addr mod LINE_BYTES. The access splits when off + size > LINE_BYTES, which requires MISALIGNED_EN=1.
  - Beat 0 covers bytes off..LINE_BYTES-1 of line A.
  - Beat 1 covers the remaining bytes at offset 0 of line A + LINE_BYTES. Address wraps modulo 2^ADDR_WIDTH.
- FSM: IDLE → REQ0 → RSP0 → (split ? REQ1 → RSP1) → DONE → IDLE. Also IDLE → ERR → IDLE.
  - REQ0/REQ1: mem_v_o=1. Address, data, mask and write flag stay stable until mem_ready_i=1, then advance to the matching RSP state.
  - RSP0/RSP1: wait for mem_v_i. For loads, capture that beat's bytes into a 4-byte merge buffer.
  - mem_v_i in any other state is ignored.
  - Exactly one outstanding memory transaction at a time. Responses are in order.
- Timing:
  - mem_v_o first rises the cycle after acceptance.
  - Minimum non-split latency: acceptance T → mem_v_o at T+1 → (ready at T+1, mem_v_i at T+2) → resp_v_o at T+3, from DONE.
  - resp_v_o is a single-cycle pulse. resp_data_o and resp_err_o are valid only while resp_v_o=1 and are 0 otherwise.
- Store formatting: store data bytes are shifted to lane off, with mask bits set for the bytes covered. Bytes outside the mask in mem_data_o are 0. A split store writes the low-order data bytes in beat 0 and the rest in beat 1.
- Load formatting: merged bytes are extended to 32 bits. lb/lh sign-extend; lbu/lhu zero-extend.
- Reset mid-operation: reset_i has priority in every state. The next state is IDLE and any in-flight transaction is abandoned. A later mem_v_i is ignored.

Test Plan:
- lw 0x100; line bytes 0x100..0x103 = 78 56 34 12 → one read, mem_addr_o=0x100, mask=0, resp_data_o=0x12345678, resp_v_o at T+3 with zero-wait memory.
- lb 0x103 with byte 0x80 → 0xFFFFFF80. lbu at the same address → 0x00000080. lhu 0x102 with bytes 34 12 → 0x00001234.
- sh 0x10E, data 0x0000BEEF → mem_addr_o=0x100, mem_w_o=1, mask=0xC000, lane 14=0xEF, lane 15=0xBE. resp_data_o=0, err=0.
- MISALIGNED_EN=1:
  - lw 0x10E, bytes 0x10E..0x111 = 11 22 33 44 → two reads, to 0x100 then 0x110 → 0x44332211.
  - sw 0x10F, data 0xAABBCCDD → beat 0 mask 0x8000 with lane 15=0xDD; beat 1 at 0x110, mask 0x0007, lanes 0..2 = CC BB AA.
- MISALIGNED_EN=0: lh 0x101 → resp_v_o and resp_err_o at T+1, mem_v_o never asserted. A load with funct3=3 also errors in either mode.
- Stall and reset:
  - mem_ready_i held low 3 cycles → mem_v_o and all mem outputs stable, req_ready_o=0.
  - reset_i asserted in RSP0 → IDLE next cycle with req_ready_o=1. A subsequent stray mem_v_i produces no resp_v_o.
